// File: rtl/booth_pkg.sv
// Shared widths and types for the Booth multiplier datapath and its frame accumulator.
// numbit is the single source of width for everything downstream.
package booth_pkg;

  localparam int numbit    = 11;
  localparam int PW_DEF    = 2*numbit;
  localparam int GUARD_DEF = 4;
  localparam int AW_DEF    = 2*numbit+4;
  localparam int CNTW_DEF  = 8;

  typedef enum logic {ACCUM, HOLD} mac_state_t;

endpackage

// File: rtl/booth_mac_acc_if.sv
// Product stream in, frame-result stream out, both valid/ready.
// The accumulator is the slave; the source/sink side is the master.
interface booth_mac_acc_if
  import booth_pkg::*;
#(
  parameter int PW   = PW_DEF,
  parameter int AW   = AW_DEF,
  parameter int CNTW = CNTW_DEF
);

  logic            in_valid;
  logic            in_ready;
  logic [PW-1:0]   in_prod;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [AW-1:0]   out_sum;
  logic [CNTW-1:0] out_cnt;
  logic            out_ovf;

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_cnt, out_ovf
  );

  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_cnt, out_ovf
  );

endinterface

// File: rtl/mac_acc_add.sv
// AW-bit accumulator adder: zero-extends the PW-bit product and exposes the carry-out.
module mac_acc_add #(
  parameter int PW = 22,
  parameter int AW = 26
) (
  input  logic [AW-1:0] acc,
  input  logic [PW-1:0] prod,
  output logic [AW-1:0] sum,
  output logic          carry
);

  assign {carry, sum} = {1'b0, acc} + {{(AW+1-PW){1'b0}}, prod};

endmodule

// File: rtl/booth_mac_acc.sv
// Frame accumulator for unsigned multiplier products: sums products until in_last,
// then presents sum, count and sticky overflow on a registered valid/ready output.
module booth_mac_acc
  import booth_pkg::*;
#(
  parameter int PW    = PW_DEF,
  parameter int GUARD = GUARD_DEF,
  parameter int CNTW  = CNTW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  booth_mac_acc_if.slave  bus
);

  localparam int AW = PW + GUARD;

  mac_state_t      state_q, state_d;
  logic [AW-1:0]   acc_q, acc_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic            out_valid_q, out_valid_d;
  logic [AW-1:0]   out_sum_q, out_sum_d;
  logic [CNTW-1:0] out_cnt_q, out_cnt_d;
  logic            out_ovf_q, out_ovf_d;

  logic            in_ready;
  logic            acc_fire;
  logic            out_fire;
  logic [AW-1:0]   add_sum;
  logic            add_carry;
  logic [CNTW-1:0] cnt_inc;

  mac_acc_add #(.PW(PW), .AW(AW)) u_add (
    .acc   (acc_q),
    .prod  (bus.in_prod),
    .sum   (add_sum),
    .carry (add_carry)
  );

  assign in_ready = (state_q == ACCUM) | ((state_q == HOLD) & bus.out_ready);
  assign acc_fire = bus.in_valid & in_ready;
  assign out_fire = out_valid_q & bus.out_ready;
  assign cnt_inc  = cnt_q + CNTW'(1);

  // acc/cnt/ovf are always zero while in HOLD, so the same add path both
  // continues a frame in ACCUM and starts a fresh one as a result retires.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_cnt_d   = out_cnt_q;
    out_ovf_d   = out_ovf_q;

    if (acc_fire) begin
      if (bus.in_last) begin
        out_sum_d   = add_sum;
        out_cnt_d   = cnt_inc;
        out_ovf_d   = ovf_q | add_carry;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end else begin
        acc_d       = add_sum;
        cnt_d       = cnt_inc;
        ovf_d       = ovf_q | add_carry;
        out_valid_d = 1'b0;
        state_d     = ACCUM;
      end
    end else if (out_fire) begin
      out_valid_d = 1'b0;
      state_d     = ACCUM;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cnt_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cnt_q   <= out_cnt_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cnt   = out_cnt_q;
  assign bus.out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_booth_mac_acc.sv
// Directed bench for booth_mac_acc: a full-precision frame model checked every cycle,
// plus literal expectations on the retired frame results.
module tb_booth_mac_acc;
  import booth_pkg::*;

  localparam int PW   = 22;
  localparam int AW   = 26;
  localparam int CNTW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  booth_mac_acc_if #(.PW(PW), .AW(AW), .CNTW(CNTW)) bus ();

  booth_mac_acc #(.PW(PW), .GUARD(4), .CNTW(CNTW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    longint sum;
    longint cnt;
    longint ovf;
    int     cyc;
  } res_t;

  res_t got_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Frame model: exact running sum, reduced modulo the output widths only at frame end.
  bit     m_started = 1'b0;
  bit     m_valid   = 1'b0;
  longint m_sum     = 0;
  longint m_cnt     = 0;
  longint m_out_sum = 0;
  longint m_out_cnt = 0;
  bit     m_out_ovf = 1'b0;
  bit     m_rdy;
  bit     m_take;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_started = 1'b1;
      m_valid   = 1'b0;
      m_sum     = 0;
      m_cnt     = 0;
      m_out_sum = 0;
      m_out_cnt = 0;
      m_out_ovf = 1'b0;
    end else if (m_started) begin
      m_rdy  = !m_valid || bus.out_ready;
      m_take = bus.in_valid && m_rdy;
      if (m_valid && bus.out_ready) m_valid = 1'b0;
      if (m_take) begin
        m_sum += longint'(bus.in_prod);
        m_cnt++;
        if (bus.in_last) begin
          m_out_sum = m_sum % (longint'(1) << AW);
          m_out_cnt = m_cnt % (longint'(1) << CNTW);
          m_out_ovf = (m_sum >= (longint'(1) << AW));
          m_valid   = 1'b1;
          m_sum     = 0;
          m_cnt     = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_started && rst_n) begin
      check("in_ready", longint'(bus.in_ready), longint'(!m_valid || bus.out_ready));
      check("out_valid", longint'(bus.out_valid), longint'(m_valid));
      if (m_valid) begin
        check("out_sum", longint'(bus.out_sum), m_out_sum);
        check("out_cnt", longint'(bus.out_cnt), m_out_cnt);
        check("out_ovf", longint'(bus.out_ovf), longint'(m_out_ovf));
      end
      if (bus.out_valid && bus.out_ready)
        got_q.push_back('{longint'(bus.out_sum), longint'(bus.out_cnt),
                          longint'(bus.out_ovf), cyc});
    end
  end

  task automatic send(input longint p, input bit last, output int waits);
    bit acc;
    acc   = 1'b0;
    waits = 0;
    bus.in_valid = 1'b1;
    bus.in_prod  = PW'(p);
    bus.in_last  = last;
    while (!acc && waits < 50) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      waits++;
    end
    if (!acc) check("send_accept", longint'(acc), 1);
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_results(input int n, input string name);
    int k;
    k = 0;
    while (got_q.size() < n && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, got_q.size(), n);
  endtask

  task automatic expect_res(input string name, input longint s, input longint c, input longint o);
    res_t r;
    if (got_q.size() > 0) begin
      r = got_q.pop_front();
      check({name, "_sum"}, r.sum, s);
      check({name, "_cnt"}, r.cnt, c);
      check({name, "_ovf"}, r.ovf, o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  int w;
  int c0;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_prod   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    check("rst_valid", longint'(bus.out_valid), 0);
    check("rst_sum",   longint'(bus.out_sum),   0);
    check("rst_cnt",   longint'(bus.out_cnt),   0);
    check("rst_ovf",   longint'(bus.out_ovf),   0);
    check("rst_ready", longint'(bus.in_ready),  1);

    // Reset mid-frame discards the partial sum 3+5.
    send(3, 0, w);
    send(5, 0, w);
    idle();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_valid", longint'(bus.out_valid), 0);
    check("mid_rst_sum",   longint'(bus.out_sum),   0);
    check("mid_rst_cnt",   longint'(bus.out_cnt),   0);
    check("mid_rst_ready", longint'(bus.in_ready),  1);
    rst_n = 1'b1;
    got_q.delete();
    send(7, 1, w);
    idle();
    wait_results(1, "mid_rst_n");
    expect_res("mid_rst", 7, 1, 0);

    // Basic frame, result visible one cycle after the last product.
    send(10, 0, w);
    send(20, 0, w);
    send(30, 1, w);
    check("basic_latency", longint'(bus.out_valid), 1);
    idle();
    wait_results(1, "basic_n");
    expect_res("basic", 60, 3, 0);

    // Backpressure: held result blocks the next frame's product.
    bus.out_ready = 1'b0;
    send(100, 1, w);
    bus.in_valid = 1'b1;
    bus.in_prod  = PW'(999);
    bus.in_last  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("bp_ready", longint'(bus.in_ready),  0);
      check("bp_valid", longint'(bus.out_valid), 1);
      check("bp_sum",   longint'(bus.out_sum),   100);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(999, 0, w);
    check("bp_release_waits", w, 1);
    send(1, 1, w);
    idle();
    wait_results(2, "bp_n");
    expect_res("bp_first", 100, 1, 0);
    expect_res("bp_next", 1000, 2, 0);

    // Back-to-back single-product frames, no bubbles.
    got_q.delete();
    for (int v = 1; v <= 8; v++) begin
      send(v, 1, w);
      check("b2b_waits", w, 1);
    end
    idle();
    wait_results(8, "b2b_n");
    if (got_q.size() == 8) begin
      c0 = got_q[0].cyc;
      for (int i = 0; i < 8; i++) check("b2b_cycle", got_q[i].cyc - c0, i);
    end
    for (int v = 1; v <= 8; v++) expect_res("b2b", v, 1, 0);

    // Overflow: 17 x 2047*2047 wraps past 2^26.
    got_q.delete();
    for (int i = 1; i <= 17; i++) send(4190209, (i == 17), w);
    send(5, 1, w);
    idle();
    wait_results(2, "ovf_n");
    expect_res("ovf", 4124689, 17, 1);
    expect_res("ovf_next", 5, 1, 0);

    // Counter wrap: 256 products of 1.
    got_q.delete();
    for (int i = 1; i <= 256; i++) send(1, (i == 256), w);
    idle();
    wait_results(1, "wrap_n");
    expect_res("wrap", 256, 0, 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
